// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory access path: access sizes, FSM states,
// default bus timeout and the alignment legality rule.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_BYTE    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mau_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic logic access_legal(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SZ_WORD: return (lo == 2'b00);
      SZ_HALF: return !lo[0];
      SZ_BYTE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension of the returned bus word.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        ld_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (addr_lo)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (mem_size_e'(size))
      SZ_BYTE: data = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/ack handshake with timeout,
// byte-lane steering for stores, extended load result and pipeline stall.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_reg2,
  input  logic        MemWrite_reg2,
  input  logic [1:0]  L_type_reg2,
  input  logic [1:0]  S_type_reg2,
  input  logic        ld_unsigned,
  input  logic [31:0] alu_OUT_reg2,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  mau_state_e  state;
  logic [CW-1:0] wait_cnt;
  mem_size_e   lat_size;
  logic [1:0]  lat_lo;
  logic        lat_unsigned;

  logic        access;
  logic        is_write;
  mem_size_e   req_size;
  logic        legal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ext_data;

  // Store wins when both strobes are set, so size and lanes follow the store.
  always_comb begin
    access     = MemRead_reg2 | MemWrite_reg2;
    is_write   = MemWrite_reg2;
    req_size   = mem_size_e'(is_write ? S_type_reg2 : L_type_reg2);
    legal      = access_legal(req_size, alu_OUT_reg2[1:0]);
    be_next    = '0;
    wdata_next = '0;
    if (is_write) begin
      case (req_size)
        SZ_BYTE: begin
          be_next    = 4'b0001 << alu_OUT_reg2[1:0];
          wdata_next = {4{store_data[7:0]}};
        end
        SZ_HALF: begin
          be_next    = 4'b0011 << alu_OUT_reg2[1:0];
          wdata_next = {2{store_data[15:0]}};
        end
        SZ_WORD: begin
          be_next    = 4'b1111;
          wdata_next = store_data;
        end
        default: begin
          be_next    = '0;
          wdata_next = '0;
        end
      endcase
    end
    mem_stall = ((state == ST_IDLE) && access) || (state == ST_REQ);
  end

  load_extend u_load_extend (
    .rdata       (dmem_rdata),
    .size        (lat_size),
    .addr_lo     (lat_lo),
    .ld_unsigned (lat_unsigned),
    .data        (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      lat_size     <= SZ_WORD;
      lat_lo       <= '0;
      lat_unsigned <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      load_data    <= '0;
      mem_err      <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (legal) begin
              state        <= ST_REQ;
              wait_cnt     <= '0;
              lat_size     <= req_size;
              lat_lo       <= alu_OUT_reg2[1:0];
              lat_unsigned <= ld_unsigned;
              dmem_req     <= 1'b1;
              dmem_we      <= is_write;
              dmem_addr    <= {alu_OUT_reg2[31:2], 2'b00};
              dmem_wdata   <= wdata_next;
              dmem_be      <= be_next;
            end else begin
              state     <= ST_DONE;
              mem_err   <= 1'b1;
              load_data <= '0;
            end
          end
        end
        ST_REQ: begin
          // An ack on the final wait cycle still completes the access.
          if (dmem_ack) begin
            state     <= ST_DONE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_be   <= '0;
            load_data <= dmem_we ? '0 : ext_data;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state     <= ST_DONE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_be   <= '0;
            mem_err   <= 1'b1;
            load_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT overridden to 4).
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        MemRead_reg2;
  logic        MemWrite_reg2;
  logic [1:0]  L_type_reg2;
  logic [1:0]  S_type_reg2;
  logic        ld_unsigned;
  logic [31:0] alu_OUT_reg2;
  logic [31:0] store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        mem_stall;
  logic        mem_err;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .MemRead_reg2  (MemRead_reg2),
    .MemWrite_reg2 (MemWrite_reg2),
    .L_type_reg2   (L_type_reg2),
    .S_type_reg2   (S_type_reg2),
    .ld_unsigned   (ld_unsigned),
    .alu_OUT_reg2  (alu_OUT_reg2),
    .store_data    (store_data),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .load_data     (load_data),
    .mem_stall     (mem_stall),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", dmem_req); end
    checks++; if (dmem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", dmem_addr); end
    checks++; if (dmem_be !== 4'b0000) begin failures++; $display("FAIL reset_be got=%b exp=0000", dmem_be); end
    checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL reset_load got=%h exp=0", load_data); end
    checks++; if (mem_err !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL reset_err_stall got=%b%b exp=00", mem_err, mem_stall); end
  endtask

  task automatic test_lb();
    MemRead_reg2 = 1'b1; L_type_reg2 = 2'b10; ld_unsigned = 1'b0; alu_OUT_reg2 = 32'h103;
    #1;
    checks++; if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL lb_c0 stall/req got=%b%b exp=10", mem_stall, dmem_req); end
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF7F;
    #1;
    checks++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin failures++; $display("FAIL lb_c1 req/stall got=%b%b exp=11", dmem_req, mem_stall); end
    checks++; if (dmem_be !== 4'b0000 || dmem_we !== 1'b0) begin failures++; $display("FAIL lb_be_we got=%b/%b exp=0000/0", dmem_be, dmem_we); end
    checks++; if (dmem_addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", dmem_addr); end
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++; if (load_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", load_data); end
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL lb_c2 stall/req got=%b%b exp=00", mem_stall, dmem_req); end
    MemRead_reg2 = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    MemRead_reg2 = 1'b1; L_type_reg2 = 2'b00; alu_OUT_reg2 = 32'h105;
    #1;
    checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL mis_c0_stall got=%b exp=1", mem_stall); end
    tick();
    #1;
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", mem_err); end
    checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL mis_load got=%h exp=0", load_data); end
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL mis_req/stall got=%b%b exp=00", dmem_req, mem_stall); end
    MemRead_reg2 = 1'b0;
    tick();
    #1;
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL mis_err_pulse got=%b exp=0", mem_err); end
    MemWrite_reg2 = 1'b1; S_type_reg2 = 2'b11; alu_OUT_reg2 = 32'h0;
    tick();
    #1;
    checks++; if (mem_err !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL size11 err/req got=%b%b exp=10", mem_err, dmem_req); end
    MemWrite_reg2 = 1'b0;
    tick();
  endtask

  task automatic test_sh_wait();
    int stalls = 0;
    MemWrite_reg2 = 1'b1; S_type_reg2 = 2'b01; alu_OUT_reg2 = 32'h202; store_data = 32'h0000_1234;
    #1;
    if (mem_stall === 1'b1) stalls++;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) dmem_ack = 1'b1;
      #1;
      if (mem_stall === 1'b1) stalls++;
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("FAIL sh_req_we c%0d got=%b%b exp=11", c, dmem_req, dmem_we); end
      checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h1234_1234 || dmem_addr !== 32'h200) begin
        failures++; $display("FAIL sh_bus c%0d got be=%b wdata=%h addr=%h exp be=1100 wdata=12341234 addr=00000200", c, dmem_be, dmem_wdata, dmem_addr);
      end
      tick();
    end
    dmem_ack = 1'b0;
    #1;
    if (mem_stall === 1'b1) stalls++;
    checks++; if (dmem_req !== 1'b0 || mem_err !== 1'b0) begin failures++; $display("FAIL sh_done req/err got=%b%b exp=00", dmem_req, mem_err); end
    checks++; if (stalls != 5) begin failures++; $display("FAIL sh_stall_cycles got=%0d exp=5", stalls); end
    MemWrite_reg2 = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    MemRead_reg2 = 1'b1; MemWrite_reg2 = 1'b1; L_type_reg2 = 2'b00; S_type_reg2 = 2'b10;
    alu_OUT_reg2 = 32'h3; store_data = 32'h0000_005A;
    tick();
    dmem_ack = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("FAIL prio_req_we got=%b%b exp=11", dmem_req, dmem_we); end
    checks++; if (dmem_be !== 4'b1000 || dmem_wdata !== 32'h5A5A_5A5A) begin failures++; $display("FAIL prio_bus got be=%b wdata=%h exp be=1000 wdata=5a5a5a5a", dmem_be, dmem_wdata); end
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++; if (mem_err !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL prio_done err/stall got=%b%b exp=00", mem_err, mem_stall); end
    MemRead_reg2 = 1'b0; MemWrite_reg2 = 1'b0;
    tick();
  endtask

  task automatic test_lw_lh();
    MemRead_reg2 = 1'b1; L_type_reg2 = 2'b00; ld_unsigned = 1'b0; alu_OUT_reg2 = 32'h10;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++; if (load_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", load_data); end
    L_type_reg2 = 2'b01; alu_OUT_reg2 = 32'h12;
    tick();
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++; if (load_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data got=%h exp=ffff8001", load_data); end
    MemRead_reg2 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    MemRead_reg2 = 1'b1; L_type_reg2 = 2'b01; ld_unsigned = 1'b1; alu_OUT_reg2 = 32'h0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (dmem_req !== 1'b1 || mem_err !== 1'b0) begin failures++; $display("FAIL to_wait c%0d req/err got=%b%b exp=10", c, dmem_req, mem_err); end
      tick();
    end
    #1;
    checks++; if (mem_err !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL to_err err/req got=%b%b exp=10", mem_err, dmem_req); end
    checks++; if (load_data !== 32'h0 || mem_stall !== 1'b0) begin failures++; $display("FAIL to_done load=%h stall=%b exp load=0 stall=0", load_data, mem_stall); end
    MemRead_reg2 = 1'b0;
    tick();
    #1;
    checks++; if (mem_err !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL to_idle err/stall got=%b%b exp=00", mem_err, mem_stall); end
  endtask

  task automatic test_reset_in_req();
    MemRead_reg2 = 1'b1; L_type_reg2 = 2'b00; ld_unsigned = 1'b0; alu_OUT_reg2 = 32'h20;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++; if (load_data !== 32'h1357_9BDF) begin failures++; $display("FAIL rr_pre_load got=%h exp=13579bdf", load_data); end
    L_type_reg2 = 2'b10; alu_OUT_reg2 = 32'h21;
    tick();
    tick();
    #1;
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rr_req got=%b exp=1", dmem_req); end
    rst = 1'b1; MemRead_reg2 = 1'b0;
    tick();
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    #1;
    checks++; if (dmem_req !== 1'b0 || load_data !== 32'h0) begin failures++; $display("FAIL rr_after_rst req=%b load=%h exp req=0 load=0", dmem_req, load_data); end
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || load_data !== 32'h0 || mem_stall !== 1'b0) begin
      failures++; $display("FAIL rr_late_ack req=%b load=%h stall=%b exp 0/0/0", dmem_req, load_data, mem_stall);
    end
  endtask

  task automatic test_back_to_back();
    int reqs = 0;
    MemWrite_reg2 = 1'b1; S_type_reg2 = 2'b00; alu_OUT_reg2 = 32'h40; store_data = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b1;
    #1;
    if (dmem_req === 1'b1) reqs++;
    checks++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'hCAFE_F00D || dmem_we !== 1'b1) begin
      failures++; $display("FAIL b2b_sw got be=%b wdata=%h we=%b exp be=1111 wdata=cafef00d we=1", dmem_be, dmem_wdata, dmem_we);
    end
    tick();
    dmem_ack = 1'b0;
    #1;
    if (dmem_req === 1'b1) reqs++;
    tick();
    MemWrite_reg2 = 1'b0; MemRead_reg2 = 1'b1; L_type_reg2 = 2'b10; ld_unsigned = 1'b1; alu_OUT_reg2 = 32'h44;
    #1;
    if (dmem_req === 1'b1) reqs++;
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b1) begin failures++; $display("FAIL b2b_gap req/stall got=%b%b exp=01", dmem_req, mem_stall); end
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_56AB;
    #1;
    if (dmem_req === 1'b1) reqs++;
    checks++; if (dmem_we !== 1'b0 || dmem_be !== 4'b0000 || dmem_addr !== 32'h44) begin
      failures++; $display("FAIL b2b_lbu_bus got we=%b be=%b addr=%h exp we=0 be=0000 addr=00000044", dmem_we, dmem_be, dmem_addr);
    end
    tick();
    dmem_ack = 1'b0;
    #1;
    if (dmem_req === 1'b1) reqs++;
    checks++; if (load_data !== 32'h0000_00AB) begin failures++; $display("FAIL b2b_lbu_data got=%h exp=000000ab", load_data); end
    MemRead_reg2 = 1'b0;
    tick();
    #1;
    if (dmem_req === 1'b1) reqs++;
    checks++; if (reqs != 2) begin failures++; $display("FAIL b2b_req_cycles got=%0d exp=2", reqs); end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog sim_time=%0t exp=finish_before_100us", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; MemRead_reg2 = 1'b0; MemWrite_reg2 = 1'b0;
    L_type_reg2 = 2'b00; S_type_reg2 = 2'b00; ld_unsigned = 1'b0;
    alu_OUT_reg2 = '0; store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    test_reset();
    test_lb();
    test_illegal();
    test_sh_wait();
    test_priority();
    test_lw_lh();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles waiting for dmem_ack before a bus error.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 MemRead_reg2  in  1  the current MEM-stage instruction is a load.
REQ-005 MemWrite_reg2  in  1  the current MEM-stage instruction is a store.
REQ-006 L_type_reg2  in  2  load size: 00 word, 01 half, 10 byte, 11 illegal.
REQ-007 S_type_reg2  in  2  store size: 00 word, 01 half, 10 byte, 11 illegal.
REQ-008 ld_unsigned  in  1  zero-extend (LBU/LHU) instead of sign-extend.
REQ-009 alu_OUT_reg2  in  32  byte address.
REQ-010 store_data  in  32  store data, right-aligned.
REQ-011 dmem_req  out  1  bus request, held until ack.
REQ-012 dmem_we  out  1  write strobe.
REQ-013 dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 dmem_wdata  out  32  store data replicated into the byte lanes.
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_ack  in  1  bus completion, one-cycle pulse.
REQ-017 dmem_rdata  in  32  read word; valid while dmem_ack is high.
REQ-018 load_data  out  32  extended load result.
REQ-019 mem_stall  out  1  freezes upstream pipeline registers (drives Enable low).
REQ-020 mem_err  out  1  one-cycle pulse on misalignment, illegal size, or timeout.

Function
REQ-021 The FSM SHALL have states IDLE, REQ and DONE.
REQ-022 In IDLE, when (MemRead_reg2|MemWrite_reg2) is set and the access is legal, the FSM SHALL move to REQ on the next edge, latching address, size, data and direction.
REQ-023 A legal access is one where word accesses have addr[1:0]=00, half accesses have addr[0]=0, and the size is not 11.
REQ-024 An illegal access SHALL pulse mem_err for one cycle, go to DONE with load_data=0, and never assert dmem_req.
REQ-025 If MemRead_reg2 and MemWrite_reg2 are both set, the write SHALL take priority.
REQ-026 In REQ, dmem_req SHALL be 1 and the address, data, we and be outputs SHALL be stable until the cycle in which dmem_ack=1.
REQ-027 On dmem_ack=1, the FSM SHALL capture the extended data into load_data and move to DONE.
REQ-028 In REQ, a wait counter SHALL count up; when it reaches TIMEOUT without an ack, the FSM SHALL pulse mem_err, set load_data=0 and go to DONE.
REQ-029 In DONE, mem_stall SHALL be 0 and load_data SHALL be valid; the FSM SHALL return to IDLE on the next edge, unconditionally.
REQ-030 mem_stall SHALL equal (IDLE & (MemRead_reg2|MemWrite_reg2)) | REQ.
REQ-031 Latency with a zero-wait memory SHALL be: stall in cycles 0 and 1, load_data valid in cycle 2.
REQ-032 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; dmem_be SHALL be 0000 for loads.
REQ-033 Load extension: select the lane by addr[1:0], then sign- or zero-extend per ld_unsigned; words pass unchanged.
REQ-034 An ack received outside REQ SHALL be ignored.

Reset
REQ-035 rst SHALL force IDLE, clear the wait counter, and drive all outputs to 0 after the edge.
REQ-036 rst asserted in REQ SHALL drop dmem_req on that edge, and a late ack SHALL be ignored.

Structure
REQ-037 Package riscv_mem_pkg SHALL hold the size enums (WORD/HALF/BYTE/ILLEGAL), the state enum, and the default TIMEOUT.
REQ-038 Sub-module load_extend (combinational) SHALL implement lane select and extension.
REQ-039 Behaviour SHALL be composed of one sequential FSM/counter process plus combinational decode.

Verification
REQ-040 LB at addr 0x103 with rdata 0x80FF_FF7F and zero-wait ack -> be=0000, load_data=0xFFFF_FF80 in cycle 2, stall for 2 cycles.
REQ-041 SH at addr 0x202 with data 0x0000_1234 and ack after 3 cycles -> be=1100, wdata=0x1234_1234, stall for 5 cycles.
REQ-042 LW at addr 0x105 -> mem_err pulse, no dmem_req, load_data=0, stall for 1 cycle.
REQ-043 LHU at addr 0x0 with no ack (TIMEOUT=4) -> mem_err after 4 REQ cycles, then DONE, then IDLE.
REQ-044 rst asserted in REQ, then ack one cycle later -> dmem_req=0 and load_data=0, ack ignored.
REQ-045 Back-to-back SW then LBU (rdata 0xAB at lane 0) -> two separate handshakes, load_data=0x0000_00AB, no duplicate request.
